// File: rtl/res_drain_ctrl_if.sv
// Output stream bundle for res_drain_ctrl: result word, valid/ready handshake and end-of-drain marker.
interface res_drain_ctrl_if #(
  parameter int OUT_W = 32
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/res_drain_ctrl.sv
// Drains N_ROWS*RES_D result words from a MAC column Res_cascade chain into a small FIFO and streams them out.
// Optional macro RES_DRAIN_SAT_EN saturates each signed word to OUT_W bits instead of truncating.
module res_drain_ctrl #(
  parameter int RES_W  = 32,
  parameter int OUT_W  = 32,
  parameter int N_ROWS = 4,
  parameter int RES_D  = 1,
  parameter int FIFO_D = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [RES_W-1:0] Res_cascade,
  output logic             Res_en,
  res_drain_ctrl_if.master out_if
);

  localparam int N_WORDS = N_ROWS * RES_D;
  localparam int CNT_W   = $clog2(N_WORDS + 1);
  localparam int PTR_W   = $clog2(FIFO_D);
  localparam int OCC_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OUT_W-1:0] data_mem [FIFO_D];
  logic             last_mem [FIFO_D];

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             push_last;
  logic [OUT_W-1:0] push_word;

  assign fifo_full  = (occ == OCC_MAX);
  assign fifo_empty = (occ == '0);
  assign Res_en     = (state == DRAIN) && !fifo_full;
  assign push       = Res_en;
  assign pop        = !fifo_empty && out_if.out_ready;
  assign push_last  = (word_cnt == LAST_IDX);

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : data_mem[rd_ptr];
  assign out_if.out_last  = fifo_empty ? 1'b0 : last_mem[rd_ptr];

`ifdef RES_DRAIN_SAT_EN
  // The word fits in OUT_W signed bits only if every bit from the OUT_W sign bit upward agrees.
  logic [RES_W-OUT_W:0] upper_bits;
  logic                 in_range;

  assign upper_bits = Res_cascade[RES_W-1:OUT_W-1];
  assign in_range   = (&upper_bits) || !(|upper_bits);

  always_comb begin
    push_word = Res_cascade[OUT_W-1:0];
    if (!in_range) begin
      if (Res_cascade[RES_W-1]) begin
        push_word = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        push_word = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end
`else
  assign push_word = Res_cascade[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_word;
      last_mem[wr_ptr] <= push_last;
    end
  end

  // Control, pointers and occupancy; a pop never frees a slot for a push in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      unique case (state)
        IDLE: begin
          if (start && !done) begin
            state    <= DRAIN;
            busy     <= 1'b1;
            word_cnt <= '0;
          end
        end
        DRAIN: begin
          if (push && push_last) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && last_mem[rd_ptr]) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_drain_ctrl.sv
// Directed testbench for res_drain_ctrl with a behavioural MAC-column shift model on Res_cascade.
// Word-width checks follow RES_DRAIN_SAT_EN when it is defined.
module tb_res_drain_ctrl;

  localparam int RES_W  = 32;
  localparam int OUT_W  = 16;
  localparam int N_ROWS = 4;
  localparam int RES_D  = 1;
  localparam int FIFO_D = 4;
  localparam int N_WORDS = N_ROWS * RES_D;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] res_cascade;
  logic             res_en;

  res_drain_ctrl_if #(.OUT_W(OUT_W)) out_if ();

  res_drain_ctrl #(
    .RES_W (RES_W),
    .OUT_W (OUT_W),
    .N_ROWS(N_ROWS),
    .RES_D (RES_D),
    .FIFO_D(FIFO_D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .Res_cascade(res_cascade),
    .Res_en     (res_en),
    .out_if     (out_if)
  );

  always #5 clk = ~clk;

  // MAC column model: each Res_en edge shifts the next word onto the registered tail.
  logic [RES_W-1:0] chain [4];
  int shift_cnt = 0;
  int base = 0;
  int rel;

  always @(posedge clk) begin
    if (res_en) shift_cnt <= shift_cnt + 1;
  end

  assign rel = shift_cnt - base;
  assign res_cascade = (rel >= 0 && rel < 4) ? chain[rel[1:0]] : 32'hDEADBEEF;

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] got_data [$];
  bit               got_last [$];
  int  done_cnt, done_cyc, last_hs_cyc, start_shift, max_occ, stall_viol, pops;
  int  snap_shifts;
  logic snap_res_en, busy_at0;
  logic [OUT_W-1:0] snap_data;

  task automatic load_chain(input logic [RES_W-1:0] w0, input logic [RES_W-1:0] w1,
                            input logic [RES_W-1:0] w2, input logic [RES_W-1:0] w3);
    chain[0] = w0;
    chain[1] = w1;
    chain[2] = w2;
    chain[3] = w3;
    base = shift_cnt;
  endtask

  // mode 0: ready always high, 1: ready on odd cycles, 2: ready low for 'hold' cycles then high
  task automatic run_drain(input int mode, input int hold, input bit poke_mid);
    logic             prev_stall;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;
    logic             ready_now;
    int               occ_now;
    got_data.delete();
    got_last.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; max_occ = 0; stall_viol = 0; pops = 0;
    snap_shifts = -1; snap_res_en = 1'bx; snap_data = 'x;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    start_shift = shift_cnt;
    start = 1'b1;
    out_if.out_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    busy_at0 = busy;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (mode)
        0:       ready_now = 1'b1;
        1:       ready_now = ((cyc % 2) == 1);
        default: ready_now = (cyc >= hold);
      endcase
      out_if.out_ready = ready_now;
      start = poke_mid && (cyc == 1);
      if (mode == 2 && cyc == hold - 1) begin
        snap_shifts = shift_cnt - start_shift;
        snap_res_en = res_en;
        snap_data   = out_if.out_data;
      end
      occ_now = (shift_cnt - start_shift) - pops;
      if (occ_now > max_occ) max_occ = occ_now;
      if (prev_stall && (out_if.out_data !== prev_data || out_if.out_last !== prev_last))
        stall_viol++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (out_if.out_valid === 1'b1 && ready_now) begin
        got_data.push_back(out_if.out_data);
        got_last.push_back(out_if.out_last);
        pops++;
        if (out_if.out_last === 1'b1) last_hs_cyc = cyc;
      end
      prev_stall = (out_if.out_valid === 1'b1) && !ready_now;
      prev_data  = out_if.out_data;
      prev_last  = out_if.out_last;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    out_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (res_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_en got %b want 0", res_en); end
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_if.out_valid); end
    checks++; if (out_if.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b want 0", out_if.out_last); end
    checks++; if (out_if.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data got %h want 0000", out_if.out_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [OUT_W-1:0] exp [4];
    exp[0] = 16'd10; exp[1] = 16'd20; exp[2] = 16'd30; exp[3] = 16'd40;
    load_chain(32'd10, 32'd20, 32'd30, 32'd40);
    run_drain(0, 0, 1'b0);
    checks++; if (busy_at0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy_at0); end
    checks++; if (got_data.size() != N_WORDS) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", got_data.size(), N_WORDS); end
    for (int i = 0; i < N_WORDS; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp[i] || got_last[i] !== (i == N_WORDS - 1)) begin
        errors++;
        $display("[TB] FAIL basic_word%0d got %h/%b want %h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 16'hxxxx,
                 (i < got_last.size()) ? got_last[i] : 1'b0, exp[i], (i == N_WORDS - 1));
      end
    end
    checks++; if (shift_cnt - start_shift != N_WORDS) begin errors++; $display("[TB] FAIL basic_shifts got %0d want %0d", shift_cnt - start_shift, N_WORDS); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done got %0d want 1", done_cnt); end
    checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d want %0d", done_cyc, last_hs_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] exp [4];
    exp[0] = 16'h0111; exp[1] = 16'h0222; exp[2] = 16'h0333; exp[3] = 16'h0444;
    load_chain(32'h111, 32'h222, 32'h333, 32'h444);
    run_drain(2, 10, 1'b0);
    checks++; if (snap_shifts != 4) begin errors++; $display("[TB] FAIL bp_shifts got %0d want 4", snap_shifts); end
    checks++; if (snap_res_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_res_en got %b want 0", snap_res_en); end
    checks++; if (snap_data !== 16'h0111) begin errors++; $display("[TB] FAIL bp_hold_data got %h want 0111", snap_data); end
    checks++; if (stall_viol != 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes want 0", stall_viol); end
    checks++; if (got_data.size() != N_WORDS) begin errors++; $display("[TB] FAIL bp_count got %0d want %0d", got_data.size(), N_WORDS); end
    for (int i = 0; i < N_WORDS; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL bp_word%0d got %h want %h", i, (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_ready_toggle();
    logic [OUT_W-1:0] exp [4];
    exp[0] = 16'hA001; exp[1] = 16'hA002; exp[2] = 16'hA003; exp[3] = 16'hA004;
    load_chain(32'hA001, 32'hA002, 32'hA003, 32'hA004);
    run_drain(1, 0, 1'b0);
    checks++; if (max_occ > FIFO_D) begin errors++; $display("[TB] FAIL toggle_occ got %0d want <= %0d", max_occ, FIFO_D); end
    checks++; if (stall_viol != 0) begin errors++; $display("[TB] FAIL toggle_stable got %0d changes want 0", stall_viol); end
    checks++; if (got_data.size() != N_WORDS) begin errors++; $display("[TB] FAIL toggle_count got %0d want %0d", got_data.size(), N_WORDS); end
    for (int i = 0; i < N_WORDS; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp[i] || got_last[i] !== (i == N_WORDS - 1)) begin
        errors++;
        $display("[TB] FAIL toggle_word%0d got %h want %h", i, (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL toggle_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    logic [OUT_W-1:0] exp [4];
    load_chain(32'd1, 32'd2, 32'd3, 32'd4);
    run_drain(0, 0, 1'b1);
    checks++; if (shift_cnt - start_shift != N_WORDS) begin errors++; $display("[TB] FAIL midstart_shifts got %0d want %0d", shift_cnt - start_shift, N_WORDS); end
    checks++; if (got_data.size() != N_WORDS) begin errors++; $display("[TB] FAIL midstart_count got %0d want %0d", got_data.size(), N_WORDS); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL midstart_done got %0d want 1", done_cnt); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL donestart_busy got %b want 0", busy); end
    checks++; if (res_en !== 1'b0) begin errors++; $display("[TB] FAIL donestart_res_en got %b want 0", res_en); end
    exp[0] = 16'h0B01; exp[1] = 16'h0B02; exp[2] = 16'h0B03; exp[3] = 16'h0B04;
    load_chain(32'hB01, 32'hB02, 32'hB03, 32'hB04);
    run_drain(0, 0, 1'b0);
    checks++; if (got_data.size() != N_WORDS) begin errors++; $display("[TB] FAIL b2b_count got %0d want %0d", got_data.size(), N_WORDS); end
    for (int i = 0; i < N_WORDS; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp[i] || got_last[i] !== (i == N_WORDS - 1)) begin
        errors++;
        $display("[TB] FAIL b2b_word%0d got %h want %h", i, (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int viol;
    load_chain(32'h51, 32'h52, 32'h53, 32'h54);
    out_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && (shift_cnt - base) < 2; i++) @(negedge clk);
    checks++; if (shift_cnt - base != 2) begin errors++; $display("[TB] FAIL rstmid_captured got %0d want 2", shift_cnt - base); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", out_if.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (res_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_res_en got %b want 0", res_en); end
    viol = 0;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done !== 1'b0 || res_en !== 1'b0 || out_if.out_valid !== 1'b0) viol++;
      @(negedge clk);
    end
    checks++; if (viol != 0) begin errors++; $display("[TB] FAIL rstmid_quiet got %0d active cycles want 0", viol); end
  endtask

  task automatic test_width();
    logic [OUT_W-1:0] exp [4];
`ifdef RES_DRAIN_SAT_EN
    exp[0] = 16'h7FFF; exp[1] = 16'h8000; exp[2] = 16'h0123; exp[3] = 16'h8000;
`else
    exp[0] = 16'h2345; exp[1] = 16'h0000; exp[2] = 16'h0123; exp[3] = 16'h8000;
`endif
    load_chain(32'h00012345, 32'hFFFF0000, 32'h00000123, 32'hFFFF8000);
    run_drain(0, 0, 1'b0);
    checks++; if (got_data.size() != N_WORDS) begin errors++; $display("[TB] FAIL width_count got %0d want %0d", got_data.size(), N_WORDS); end
    for (int i = 0; i < N_WORDS; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL width_word%0d got %h want %h", i, (i < got_data.size()) ? got_data[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ready_toggle();
    test_start_ignored();
    test_reset_mid();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
